dual_port_ram_arb: RTL

//   Parametrised true dual-port RAM, two read/write ports on one clock, with

---
 rtl/dual_port_ram_arb.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/dual_port_ram_arb.sv
// dual_port_ram_arb
//   True dual-port RAM shared by two datapath masters on one clock. Same-address
//   conflicts are resolved deterministically, read-during-write behaviour is
//   selectable, and the whole array is swept to zero after every reset.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   ST_CLEAR | zeroing mem[clr_addr] each cycle, user requests ignored
//   ST_RUN   | normal dual-port operation
//
// Ports
//   clk, rst                    clock, async active-high reset
//   ena/wea/addra/dia           port A request, write enable, address, data
//   doa/vala                    port A read data and its 1-cycle valid pulse
//   enb/web/addrb/dib/dob/valb  port B, same as port A
//   init_busy                   clear sweep running
//   collision                   pulse, same-address conflict on previous cycle
//   coll_count                  saturating collision count, cleared by rst
module dual_port_ram_arb #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDR_WIDTH    = 6,
  parameter int RDW_MODE      = 0,
  parameter int OUT_REG       = 0,
  parameter int COLL_PRIORITY = 0,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic                  wea,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [DATA_WIDTH-1:0] dia,
  output logic [DATA_WIDTH-1:0] doa,
  output logic                  vala,
  input  logic                  enb,
  input  logic                  web,
  input  logic [ADDR_WIDTH-1:0] addrb,
  input  logic [DATA_WIDTH-1:0] dib,
  output logic [DATA_WIDTH-1:0] dob,
  output logic                  valb,
  output logic                  init_busy,
  output logic                  collision,
  output logic [CNT_WIDTH-1:0]  coll_count
);

  localparam int   DEPTH  = 2**ADDR_WIDTH;
  localparam logic B_WINS = (COLL_PRIORITY != 0);
  localparam logic RDW_NEW = (RDW_MODE != 0);

  typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  run, clr_we;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  acc_a, acc_b, same_addr, coll, wr_a, wr_b;
  logic [DATA_WIDTH-1:0] old_a, old_b, rd_a, rd_b;

  logic                  va_s1, vb_s1;
  logic [DATA_WIDTH-1:0] da_s1, db_s1;

  // state register; clr_addr wraps back to 0 on leaving CLEAR
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_CLEAR;
      clr_addr <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_CLEAR) clr_addr <= clr_addr + ADDR_WIDTH'(1);
    end
  end

  // next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_CLEAR: if (clr_addr == ADDR_WIDTH'(DEPTH-1)) state_nxt = ST_RUN;
      ST_RUN:   state_nxt = ST_RUN;
      default:  state_nxt = ST_CLEAR;
    endcase
  end

  // state outputs
  always_comb begin
    run    = 1'b0;
    clr_we = 1'b0;
    case (state)
      ST_CLEAR: clr_we = 1'b1;
      ST_RUN:   run    = 1'b1;
      default:  clr_we = 1'b1;
    endcase
  end

  assign init_busy = ~run;

  assign acc_a     = run & ena;
  assign acc_b     = run & enb;
  assign same_addr = (addra == addrb);
  assign coll      = acc_a & acc_b & same_addr & (wea | web);

  // on a write-write collision only the priority port's write reaches the array
  assign wr_a = acc_a & wea & ~(coll & web & B_WINS);
  assign wr_b = acc_b & web & ~(coll & wea & ~B_WINS);

  assign old_a = mem[addra];
  assign old_b = mem[addrb];

  // write-first returns whatever the array holds after this cycle's writes
  always_comb begin
    rd_a = old_a;
    rd_b = old_b;
    if (RDW_NEW) begin
      if (wr_a)                  rd_a = dia;
      else if (wr_b & same_addr) rd_a = dib;
      if (wr_b)                  rd_b = dib;
      else if (wr_a & same_addr) rd_b = dia;
    end
  end

  // array has no reset; the sweep zeroes it instead
  always_ff @(posedge clk) begin
    if (clr_we) mem[clr_addr] <= '0;
    if (wr_a)   mem[addra]    <= dia;
    if (wr_b)   mem[addrb]    <= dib;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      va_s1      <= 1'b0;
      vb_s1      <= 1'b0;
      da_s1      <= '0;
      db_s1      <= '0;
      collision  <= 1'b0;
      coll_count <= '0;
    end else begin
      va_s1     <= acc_a;
      vb_s1     <= acc_b;
      if (acc_a) da_s1 <= rd_a;
      if (acc_b) db_s1 <= rd_b;
      collision <= coll;
      if (coll && (coll_count != {CNT_WIDTH{1'b1}}))
        coll_count <= coll_count + CNT_WIDTH'(1);
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vala <= 1'b0;
          valb <= 1'b0;
          doa  <= '0;
          dob  <= '0;
        end else begin
          vala <= va_s1;
          valb <= vb_s1;
          if (va_s1) doa <= da_s1;
          if (vb_s1) dob <= db_s1;
        end
      end
    end else begin : g_noreg
      assign vala = va_s1;
      assign valb = vb_s1;
      assign doa  = da_s1;
      assign dob  = db_s1;
    end
  endgenerate

endmodule
